// File: rtl/qspi_flash_responder_pkg.sv
// Shared constants, state encoding and byte-lane helper for the QSPI flash responder.
package qspi_flash_responder_pkg;

  localparam logic [7:0] CMD_QIO_READ = 8'hEB;
  localparam logic [3:0] MODE_CONT    = 4'hA;
  localparam int         CMD_BITS     = 8;
  localparam int         ADDR_NIBS    = 6;
  localparam int         MODE_NIBS    = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_MODE   = 3'd3,
    ST_DUMMY  = 3'd4,
    ST_DATA   = 3'd5,
    ST_IGNORE = 3'd6
  } qspi_state_e;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    word_byte = word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/qspi_flash_responder_if.sv
// SPI pin bundle between the initiator (master) and the flash responder (slave).
interface qspi_flash_responder_if;
  logic       sck;
  logic       ce_n;
  logic [3:0] io_i;
  logic [3:0] io_o;
  logic       io_oe;

  modport master (output sck, ce_n, io_i, input io_o, io_oe);
  modport slave  (input sck, ce_n, io_i, output io_o, io_oe);
endinterface

// File: rtl/qspi_flash_responder_sck_edge.sv
// SCK edge detector: registered sck level held low while deselected, rise/fall pulses.
module qspi_sck_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic ce_n,
  output logic rise,
  output logic fall
);
  logic sck_q_r;

  // delayed sck level, cleared while deselected so the first edge after ce_n falls is a clean rise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q_r <= 1'b0;
    end else if (ce_n) begin
      sck_q_r <= 1'b0;
    end else begin
      sck_q_r <= sck;
    end
  end

  assign rise = sck & ~sck_q_r;
  assign fall = ~sck & sck_q_r;
endmodule

// File: rtl/qspi_flash_responder.sv
// Quad I/O Fast Read (0xEB) flash responder: decodes command/address/mode/dummy
// phases from sampled SPI pins and streams bytes from a word-wide memory.
module qspi_flash_responder
  import qspi_flash_responder_pkg::*;
#(
  parameter int MEM_AW    = 10,
  parameter int DUMMY_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  qspi_flash_responder_if.slave spi,
  output logic                  mem_rd,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [31:0]           mem_rdata,
  output logic                  cont_mode
);
  localparam int PW = MEM_AW + 2;
  localparam logic [MEM_AW-1:0] WORD_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]     BYTE_ONE = {{(PW-1){1'b0}}, 1'b1};

  qspi_state_e       state_r, state_s;
  logic [7:0]        ctr_r, ctr_s;
  logic [6:0]        cmd_sr_r, cmd_sr_s;
  logic [3:0]        mode_hi_r, mode_hi_s;
  logic [PW-1:0]     ptr_r, ptr_s;
  logic              nib_r, nib_s, first_r, first_s, rd_pend_r, rd_pend_s;
  logic [31:0]       cur_word_r, cur_word_s, next_word_r, next_word_s;
  logic [3:0]        io_o_r, io_o_s;
  logic              io_oe_r, io_oe_s, mem_rd_r, mem_rd_s, cont_mode_r, cont_mode_s;
  logic [MEM_AW-1:0] mem_addr_r, mem_addr_s;
  logic [7:0]        byte_s;
  logic              rise_s, fall_s;

  qspi_sck_edge u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sck  (spi.sck),
    .ce_n (spi.ce_n),
    .rise (rise_s),
    .fall (fall_s)
  );

  // next-state and output decode; ce_n high overrides every phase
  always_comb begin
    state_s     = state_r;
    ctr_s       = ctr_r;
    cmd_sr_s    = cmd_sr_r;
    mode_hi_s   = mode_hi_r;
    ptr_s       = ptr_r;
    nib_s       = nib_r;
    first_s     = first_r;
    rd_pend_s   = 1'b0;
    cur_word_s  = cur_word_r;
    next_word_s = next_word_r;
    io_o_s      = io_o_r;
    io_oe_s     = io_oe_r;
    mem_rd_s    = 1'b0;
    mem_addr_s  = mem_addr_r;
    cont_mode_s = cont_mode_r;
    byte_s      = word_byte(cur_word_r, ptr_r[1:0]);
    if (spi.ce_n) begin
      state_s = ST_IDLE;
      ctr_s   = 8'd0;
      io_oe_s = 1'b0;
      first_s = 1'b0;
    end else begin
      rd_pend_s = mem_rd_r;
      // the word fetched at the end of ADDR is the current word, later ones are prefetches
      if (rd_pend_r && first_r) begin
        cur_word_s = mem_rdata;
        first_s    = 1'b0;
      end else if (rd_pend_r) begin
        next_word_s = mem_rdata;
      end else begin
        next_word_s = next_word_r;
      end
      case (state_r)
        ST_IDLE: begin
          ctr_s   = 8'd0;
          state_s = cont_mode_r ? ST_ADDR : ST_CMD;
        end
        ST_CMD: begin
          if (rise_s && (ctr_r == 8'(CMD_BITS - 1))) begin
            ctr_s   = 8'd0;
            state_s = ({cmd_sr_r, spi.io_i[0]} == CMD_QIO_READ) ? ST_ADDR : ST_IGNORE;
          end else if (rise_s) begin
            cmd_sr_s = {cmd_sr_r[5:0], spi.io_i[0]};
            ctr_s    = ctr_r + 8'd1;
          end else begin
            ctr_s = ctr_r;
          end
        end
        ST_ADDR: begin
          if (rise_s) begin
            ptr_s = {ptr_r[PW-5:0], spi.io_i};
            if (ctr_r == 8'(ADDR_NIBS - 1)) begin
              ctr_s      = 8'd0;
              state_s    = ST_MODE;
              mem_rd_s   = 1'b1;
              mem_addr_s = ptr_s[PW-1:2];
              first_s    = 1'b1;
            end else begin
              ctr_s = ctr_r + 8'd1;
            end
          end else begin
            ctr_s = ctr_r;
          end
        end
        ST_MODE: begin
          if (rise_s && (ctr_r == 8'(MODE_NIBS - 1))) begin
            ctr_s       = 8'd0;
            state_s     = ST_DUMMY;
            cont_mode_s = (mode_hi_r == MODE_CONT);
            // an unaligned start never hits the aligned-byte prefetch for its second word
            if (ptr_r[1:0] != 2'b00) begin
              mem_rd_s   = 1'b1;
              mem_addr_s = ptr_r[PW-1:2] + WORD_ONE;
            end else begin
              mem_rd_s = 1'b0;
            end
          end else if (rise_s) begin
            mode_hi_s = spi.io_i;
            ctr_s     = ctr_r + 8'd1;
          end else begin
            ctr_s = ctr_r;
          end
        end
        ST_DUMMY: begin
          if (rise_s && (ctr_r == 8'(DUMMY_CYC - 1))) begin
            ctr_s   = 8'd0;
            state_s = ST_DATA;
            nib_s   = 1'b0;
          end else if (rise_s) begin
            ctr_s = ctr_r + 8'd1;
          end else begin
            ctr_s = ctr_r;
          end
        end
        ST_DATA: begin
          if (fall_s) begin
            io_o_s  = nib_r ? byte_s[3:0] : byte_s[7:4];
            io_oe_s = 1'b1;
          end else if (rise_s && !nib_r) begin
            nib_s = 1'b1;
            if (ptr_r[1:0] == 2'b00) begin
              mem_rd_s   = 1'b1;
              mem_addr_s = ptr_r[PW-1:2] + WORD_ONE;
            end else begin
              mem_rd_s = 1'b0;
            end
          end else if (rise_s) begin
            nib_s = 1'b0;
            ptr_s = ptr_r + BYTE_ONE;
            if (ptr_r[1:0] == 2'b11) begin
              cur_word_s = next_word_r;
            end else begin
              cur_word_s = cur_word_r;
            end
          end else begin
            nib_s = nib_r;
          end
        end
        ST_IGNORE: begin
          state_s = ST_IGNORE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ctr_r       <= 8'd0;
      cmd_sr_r    <= 7'd0;
      mode_hi_r   <= 4'd0;
      ptr_r       <= '0;
      nib_r       <= 1'b0;
      first_r     <= 1'b0;
      rd_pend_r   <= 1'b0;
      cur_word_r  <= 32'd0;
      next_word_r <= 32'd0;
      io_o_r      <= 4'd0;
      io_oe_r     <= 1'b0;
      mem_rd_r    <= 1'b0;
      mem_addr_r  <= '0;
      cont_mode_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      ctr_r       <= ctr_s;
      cmd_sr_r    <= cmd_sr_s;
      mode_hi_r   <= mode_hi_s;
      ptr_r       <= ptr_s;
      nib_r       <= nib_s;
      first_r     <= first_s;
      rd_pend_r   <= rd_pend_s;
      cur_word_r  <= cur_word_s;
      next_word_r <= next_word_s;
      io_o_r      <= io_o_s;
      io_oe_r     <= io_oe_s;
      mem_rd_r    <= mem_rd_s;
      mem_addr_r  <= mem_addr_s;
      cont_mode_r <= cont_mode_s;
    end
  end

  assign spi.io_o  = io_o_r;
  assign spi.io_oe = io_oe_r;
  assign mem_rd    = mem_rd_r;
  assign mem_addr  = mem_addr_r;
  assign cont_mode = cont_mode_r;
endmodule
